// File: rtl/lpc_record_sequencer.sv
// Output scheduler for the LPC decoder: filters strobed transactions, queues them in a
// record FIFO and serialises each as a 10-byte record on a valid/ready byte stream.
module lpc_record_sequencer #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] FILTER_MASK = 16'hFFFF
) (
    input  logic                     lpc_clock,
    input  logic                     lpc_reset,
    input  logic                     in_valid,
    input  logic [3:0]               in_cyctype_dir,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_data,
    input  logic [2:0]               in_data_size,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t      state, next_state;
    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [79:0] shifter;
    logic [3:0]  byte_idx;
    logic [7:0]  drop_cnt;
    logic        full, accept, push, drop, pop, handshake;

    // Fullness is taken from the pointers before this edge, so a push into a full FIFO
    // drops even when LOAD frees a slot in the same cycle.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept    = in_valid && FILTER_MASK[in_cyctype_dir];
    assign push      = accept && !full;
    assign drop      = accept && full;
    assign pop       = (state == LOAD);
    assign handshake = (state == SEND) && tx_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    // NOTE: the record RAM carries no reset; the pointers alone define which slots are live.
    always_ff @(posedge lpc_clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{in_cyctype_dir, in_data_size, in_addr, in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            drop_cnt <= 8'h00;
            overflow <= 1'b0;
        end else if (pop) begin
            // The snapshot in b9 takes the old count; a drop in this same cycle starts the next one.
            drop_cnt <= drop ? 8'h01 : 8'h00;
            overflow <= drop;
        end else if (drop) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            shifter  <= '0;
            byte_idx <= '0;
        end else if (pop) begin
            shifter  <= {head.cyctype_dir, 1'b0, head.size, head.addr, head.data, drop_cnt};
            byte_idx <= '0;
        end else if (handshake) begin
            shifter  <= {shifter[71:0], 8'h00};
            byte_idx <= byte_idx + 4'd1;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) state <= IDLE;
        else            state <= next_state;
    end

    // NOTE: next_state is defaulted first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fifo_level != '0) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND:    if (tx_ready && byte_idx == 4'd9) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign tx_valid   = (state == SEND);
    assign tx_data    = tx_valid ? shifter[79:72] : 8'h00;
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_lpc_record_sequencer.sv
// Self-checking bench for lpc_record_sequencer: record vector table, directed corner
// sequences and a randomized run against a queue-based transaction model.
module tb_lpc_record_sequencer;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] MASK_F = 16'hFFFE;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset = 1'b0;
    logic        in_valid  = 1'b0;
    logic [3:0]  in_cyctype_dir = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_data_size = '0;
    logic        tx_ready = 1'b0;

    logic [7:0]  tx_data, tx_data_f;
    logic        tx_valid, tx_valid_f, overflow, overflow_f;
    logic [2:0]  fifo_level, fifo_level_f;

    lpc_record_sequencer #(.DEPTH(DEPTH), .FILTER_MASK(16'hFFFF)) dut (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .in_valid(in_valid),
        .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
        .in_data_size(in_data_size), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .overflow(overflow), .fifo_level(fifo_level));

    lpc_record_sequencer #(.DEPTH(DEPTH), .FILTER_MASK(MASK_F)) dut_f (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .in_valid(in_valid),
        .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
        .in_data_size(in_data_size), .tx_data(tx_data_f), .tx_valid(tx_valid_f),
        .tx_ready(tx_ready), .overflow(overflow_f), .fifo_level(fifo_level_f));

    always #5 lpc_clock = ~lpc_clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model of the filtered instance ----------------
    typedef struct {
        logic [3:0]  ctd;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t       mq[$];        // records waiting in the FIFO
    logic [7:0] mb[$];        // bytes of the record being transmitted
    bit         m_loadp;      // one cycle of load pending after the sender went idle
    int         m_drops;
    bit         m_ovf;

    function automatic void model_edge();
        bit   acc, full, drop, was_load, was_idle;
        rec_t r;
        acc      = in_valid && MASK_F[in_cyctype_dir];
        full     = (mq.size() == DEPTH);
        drop     = acc && full;
        was_load = m_loadp;
        was_idle = !m_loadp && (mb.size() == 0);
        if (mb.size() > 0 && tx_ready) void'(mb.pop_front());
        if (was_load) begin
            r = mq.pop_front();
            mb.push_back({r.ctd, 1'b0, r.sz});
            for (int k = 3; k >= 0; k--) mb.push_back(r.addr[8*k +: 8]);
            for (int k = 3; k >= 0; k--) mb.push_back(r.data[8*k +: 8]);
            mb.push_back(m_drops[7:0]);
            m_drops = drop ? 1 : 0;
            m_ovf   = drop;
            m_loadp = 1'b0;
        end else begin
            if (was_idle && mq.size() > 0) m_loadp = 1'b1;
            if (drop) begin
                if (m_drops < 255) m_drops++;
                m_ovf = 1'b1;
            end
        end
        if (acc && !full) begin
            r.ctd = in_cyctype_dir; r.sz = in_data_size; r.addr = in_addr; r.data = in_data;
            mq.push_back(r);
        end
    endfunction

    always @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            mq.delete(); mb.delete();
            m_loadp = 1'b0; m_drops = 0; m_ovf = 1'b0;
        end else begin
            model_edge();
        end
        cyc++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge lpc_clock);
        #1;
    endtask

    task automatic strobe(input logic [3:0] c, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_cyctype_dir = c; in_data_size = s; in_addr = a; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        lpc_reset = 1'b0;
        tick(); tick();
        lpc_reset = 1'b1;
        tick();
    endtask

    logic [7:0] got[$];
    int         gcyc[$];
    logic       govf[$];
    int         peak;

    // Gathers accepted bytes of the default-mask instance, bounded by a cycle budget.
    task automatic collect(input int n, input int budget);
        got.delete(); gcyc.delete(); govf.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data); gcyc.push_back(cyc); govf.push_back(overflow);
            end
            tick();
        end
        check("collect_len", got.size(), n);
    endtask

    typedef struct {
        logic [3:0]  ctd;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  exp [10];
    } vec_t;

    vec_t vecs [4];
    logic [7:0] prev_data;
    bit         prev_stall;

    initial begin
        vecs[0].ctd = 4'b0100; vecs[0].sz = 3'd1; vecs[0].addr = 32'hAFFE7FE5; vecs[0].data = 32'h0000DF6C;
        vecs[0].exp = '{8'h41, 8'hAF, 8'hFE, 8'h7F, 8'hE5, 8'h00, 8'h00, 8'hDF, 8'h6C, 8'h00};
        vecs[1].ctd = 4'hA; vecs[1].sz = 3'd4; vecs[1].addr = 32'h12345678; vecs[1].data = 32'h9ABCDEF0;
        vecs[1].exp = '{8'hA4, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        vecs[2].ctd = 4'hE; vecs[2].sz = 3'd7; vecs[2].addr = 32'hFFFFFFFF; vecs[2].data = 32'h00000001;
        vecs[2].exp = '{8'hE7, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        vecs[3].ctd = 4'h3; vecs[3].sz = 3'd2; vecs[3].addr = 32'h00000000; vecs[3].data = 32'h80000000;
        vecs[3].exp = '{8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_fifo_level", fifo_level, 0);
        lpc_reset = 1'b1;
        tick();

        // Table: latency and byte order of single records
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(vecs[i].ctd, vecs[i].sz, vecs[i].addr, vecs[i].data);
            check("lat_k0_valid", tx_valid, 0);
            check("lat_k0_level", fifo_level, 1);
            tick();
            check("lat_k1_valid", tx_valid, 0);
            tick();
            check("lat_k2_valid", tx_valid, 1);
            collect(10, 40);
            for (int b = 0; b < 10 && b < got.size(); b++) check($sformatf("vec%0d_b%0d", i, b), got[b], vecs[i].exp[b]);
            check("vec_end_valid", tx_valid, 0);
            check("vec_end_level", fifo_level, 0);
        end

        // Two strobes 3 cycles apart: order, 2-cycle gap, level peak
        peak = 0;
        fork
            begin
                strobe(vecs[0].ctd, vecs[0].sz, vecs[0].addr, vecs[0].data);
                tick(); tick();
                strobe(vecs[1].ctd, vecs[1].sz, vecs[1].addr, vecs[1].data);
            end
            collect(20, 80);
        join
        for (int b = 0; b < 20 && b < got.size(); b++)
            check($sformatf("pair_b%0d", b), got[b], (b < 10) ? vecs[0].exp[b] : vecs[1].exp[b-10]);
        if (gcyc.size() == 20) check("pair_gap", gcyc[10] - gcyc[9], 3);
        check("pair_peak", peak, 1);

        // Overflow: 8 strobes with the sink stalled
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) strobe(4'b0100, 3'd1, i, ~i);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", tx_valid, 1);
        check("ovf_b0", tx_data, 8'h41);
        tx_ready = 1'b1;
        collect(50, 200);
        if (got.size() == 50) begin
            for (int r = 0; r < 5; r++) begin
                check($sformatf("ovf_rec%0d_addr", r), got[r*10+4], r);
                check($sformatf("ovf_rec%0d_b9", r), got[r*10+9], (r == 1) ? 3 : 0);
            end
            check("ovf_during_rec1", govf[9], 1);
            check("ovf_clear_rec2", govf[10], 0);
        end
        check("ovf_final_flag", overflow, 0);

        // Drop counter saturation
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 262; i++) strobe(4'b0100, 3'd1, i, i);
        tx_ready = 1'b1;
        collect(20, 80);
        if (got.size() == 20) check("sat_b9", got[19], 8'hFF);
        tx_ready = 1'b0;
        for (int c = 0; c < 60 && tx_valid_f; c++) tick();

        // Filter: masked cycle type is ignored silently
        do_reset();
        tx_ready = 1'b1;
        strobe(4'h0, 3'd1, 32'h1, 32'h2);
        for (int c = 0; c < 4; c++) begin
            check("flt_level", fifo_level_f, 0);
            check("flt_valid", tx_valid_f, 0);
            tick();
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(4'h4, 3'd1, i, i);
        check("flt_full_level", fifo_level_f, 4);
        strobe(4'h0, 3'd1, 32'h5, 32'h5);
        check("flt_no_drop", overflow_f, 0);
        check("flt_level_kept", fifo_level_f, 4);
        strobe(4'h4, 3'd1, 32'h6, 32'h6);
        check("flt_real_drop", overflow_f, 1);

        // Stall stability with toggling ready
        do_reset();
        tx_ready = 1'b1;
        strobe(vecs[0].ctd, vecs[0].sz, vecs[0].addr, vecs[0].data);
        got.delete();
        prev_stall = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 80 && got.size() < 10; c++) begin
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            tx_ready = ~tx_ready;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            tick();
        end
        check("toggle_len", got.size(), 10);
        for (int b = 0; b < 10 && b < got.size(); b++) check($sformatf("toggle_b%0d", b), got[b], vecs[0].exp[b]);
        check("toggle_end_valid", tx_valid, 0);

        // Reset in the middle of a record
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) strobe(vecs[i].ctd, vecs[i].sz, vecs[i].addr, vecs[i].data);
        check("mid_level", fifo_level, 2);
        tx_ready = 1'b1;
        repeat (4) tick();
        check("mid_b4", tx_data, 8'hE5);
        #3 lpc_reset = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_data", tx_data, 8'h00);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ovf", overflow, 0);
        #2 lpc_reset = 1'b1;
        tick();
        strobe(vecs[3].ctd, vecs[3].sz, vecs[3].addr, vecs[3].data);
        tick(); tick();
        collect(10, 40);
        for (int b = 0; b < 10 && b < got.size(); b++) check($sformatf("post_rst_b%0d", b), got[b], vecs[3].exp[b]);
        check("post_rst_level", fifo_level, 0);

        // Randomized run of the filtered instance against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid       = ($urandom_range(0, 99) < 35);
            in_cyctype_dir = 4'($urandom_range(0, 15));
            in_data_size   = 3'($urandom_range(0, 7));
            in_addr        = $urandom;
            in_data        = $urandom;
            tx_ready       = ($urandom_range(0, 99) < (((c / 300) % 2 == 1) ? 90 : 20));
            tick();
            check("rnd_valid", tx_valid_f, (mb.size() > 0));
            check("rnd_data", tx_data_f, (mb.size() > 0) ? mb[0] : 8'h00);
            check("rnd_level", fifo_level_f, mq.size());
            check("rnd_ovf", overflow_f, m_ovf);
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
